// File: rtl/axi_lite_write_arbiter.sv
// axi_lite_write_arbiter: round-robin sharing of one AXI4-Lite write port (AW/W/B) among NUM_M masters
module axi_lite_write_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int GNT_W  = 1
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [NUM_M-1:0]          M_AWVALID,
  input  logic [NUM_M*ADDR_W-1:0]   M_AWADDR,
  input  logic [NUM_M*3-1:0]        M_AWPROT,
  output logic [NUM_M-1:0]          M_AWREADY,
  input  logic [NUM_M-1:0]          M_WVALID,
  input  logic [NUM_M*DATA_W-1:0]   M_WDATA,
  input  logic [NUM_M*DATA_W/8-1:0] M_WSTRB,
  output logic [NUM_M-1:0]          M_WREADY,
  output logic [NUM_M-1:0]          M_BVALID,
  output logic [1:0]                M_BRESP,
  input  logic [NUM_M-1:0]          M_BREADY,
  output logic                      S_AWVALID,
  output logic [ADDR_W-1:0]         S_AWADDR,
  output logic [2:0]                S_AWPROT,
  input  logic                      S_AWREADY,
  output logic                      S_WVALID,
  output logic [DATA_W-1:0]         S_WDATA,
  output logic [DATA_W/8-1:0]       S_WSTRB,
  input  logic                      S_WREADY,
  input  logic                      S_BVALID,
  input  logic [1:0]                S_BRESP,
  output logic                      S_BREADY,
  output logic [GNT_W-1:0]          GRANT,
  output logic                      BUSY
);
  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
  state_t state_q, state_d;
  logic [GNT_W-1:0] grant_q, grant_d, last_q, last_d, idx, pick;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d, found, in_addr, in_resp;
  logic [GNT_W:0] sum;
  logic [NUM_M-1:0] sel;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    aw_done_d = aw_done_q;
    w_done_d = w_done_q;
    found = 1'b0;
    sum = '0;
    idx = '0;
    pick = grant_q;
    in_addr = state_q == ADDR;
    in_resp = state_q == RESP;
    sel = NUM_M'(1) << grant_q;
    S_AWVALID = in_addr & M_AWVALID[grant_q] & ~aw_done_q;
    S_WVALID = in_addr & M_WVALID[grant_q] & ~w_done_q;
    S_AWADDR = in_addr ? ADDR_W'(M_AWADDR >> (ADDR_W * grant_q)) : '0;
    S_AWPROT = in_addr ? 3'(M_AWPROT >> (3 * grant_q)) : '0;
    S_WDATA = in_addr ? DATA_W'(M_WDATA >> (DATA_W * grant_q)) : '0;
    S_WSTRB = in_addr ? (DATA_W/8)'(M_WSTRB >> (DATA_W / 8 * grant_q)) : '0;
    M_AWREADY = (in_addr & S_AWREADY & ~aw_done_q) ? sel : '0;
    M_WREADY = (in_addr & S_WREADY & ~w_done_q) ? sel : '0;
    M_BVALID = (in_resp & S_BVALID) ? sel : '0;
    M_BRESP = in_resp ? S_BRESP : '0;
    S_BREADY = in_resp & M_BREADY[grant_q];
    GRANT = grant_q;
    BUSY = state_q != IDLE;
    // first requester after the previous owner, wrapping modulo NUM_M
    for (int k = 1; k <= NUM_M; k++) begin
      sum = {1'b0, last_q} + (GNT_W+1)'(k);
      idx = sum >= (GNT_W+1)'(NUM_M) ? GNT_W'(sum - (GNT_W+1)'(NUM_M)) : GNT_W'(sum);
      if (!found && M_AWVALID[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
    if (state_q == IDLE) begin
      if (found) begin
        state_d = ADDR;
        grant_d = pick;
      end
    end else if (in_addr) begin
      aw_done_d = aw_done_q | (S_AWVALID & S_AWREADY);
      w_done_d = w_done_q | (S_WVALID & S_WREADY);
      state_d = (aw_done_d & w_done_d) ? RESP : ADDR;
    end else if (S_BVALID & S_BREADY) begin
      aw_done_d = 1'b0;
      w_done_d = 1'b0;
      last_d = grant_q;
      state_d = IDLE;
    end
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= GNT_W'(NUM_M - 1);
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
// tb_axi_lite_write_arbiter: directed checks of grant order, channel decoupling, B backpressure and reset
module tb_axi_lite_write_arbiter;
  logic ACLK = 1'b0, ARESETn;
  logic [1:0] M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY, M_BRESP, S_BRESP;
  logic [63:0] M_AWADDR, M_WDATA;
  logic [5:0] M_AWPROT;
  logic [7:0] M_WSTRB;
  logic S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY, BUSY;
  logic [31:0] S_AWADDR, S_WDATA;
  logic [2:0] S_AWPROT;
  logic [3:0] S_WSTRB;
  logic [0:0] GRANT;
  int checks = 0, errors = 0;
  always #5 ACLK = ~ACLK;
  axi_lite_write_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .M_AWVALID(M_AWVALID), .M_AWADDR(M_AWADDR), .M_AWPROT(M_AWPROT), .M_AWREADY(M_AWREADY),
    .M_WVALID(M_WVALID), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WREADY(M_WREADY),
    .M_BVALID(M_BVALID), .M_BRESP(M_BRESP), .M_BREADY(M_BREADY),
    .S_AWVALID(S_AWVALID), .S_AWADDR(S_AWADDR), .S_AWPROT(S_AWPROT), .S_AWREADY(S_AWREADY),
    .S_WVALID(S_WVALID), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WREADY(S_WREADY),
    .S_BVALID(S_BVALID), .S_BRESP(S_BRESP), .S_BREADY(S_BREADY),
    .GRANT(GRANT), .BUSY(BUSY)
  );
  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask
  task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
    checks++;
    if (o !== e) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", t, o, e);
    end
  endtask
  initial begin
    ARESETn = 1'b0;
    M_AWVALID = '0; M_AWADDR = '0; M_AWPROT = '0; M_WVALID = '0; M_WDATA = '0; M_WSTRB = '0; M_BREADY = '0;
    S_AWREADY = 1'b0; S_WREADY = 1'b0; S_BVALID = 1'b0; S_BRESP = '0;
    cyc(); cyc();
    chk("reset_busy", BUSY, 0);
    chk("reset_grant", GRANT, 0);
    chk("reset_awvalid", S_AWVALID, 0);
    chk("reset_awready", M_AWREADY, 0);
    ARESETn = 1'b1;
    M_AWVALID = 2'b01; M_AWADDR[31:0] = 32'h10; M_AWPROT[2:0] = 3'h5;
    M_WVALID = 2'b01; M_WDATA[31:0] = 32'hDEADBEEF; M_WSTRB[3:0] = 4'hF;
    S_AWREADY = 1'b1; S_WREADY = 1'b1; M_BREADY = 2'b11;
    #1;
    chk("idle_awvalid", S_AWVALID, 0);
    cyc();
    chk("single_grant", GRANT, 0);
    chk("single_busy", BUSY, 1);
    chk("single_awvalid", S_AWVALID, 1);
    chk("single_awaddr", S_AWADDR, 32'h10);
    chk("single_awprot", S_AWPROT, 5);
    chk("single_wvalid", S_WVALID, 1);
    chk("single_wdata", S_WDATA, 32'hDEADBEEF);
    chk("single_wstrb", S_WSTRB, 4'hF);
    chk("single_awready", M_AWREADY, 1);
    chk("single_wready", M_WREADY, 1);
    cyc();
    M_AWVALID = '0; M_WVALID = '0; S_BVALID = 1'b1; S_BRESP = 2'b00;
    #1;
    chk("single_bvalid", M_BVALID, 1);
    chk("single_bresp", M_BRESP, 0);
    chk("single_bready", S_BREADY, 1);
    chk("single_resp_awvalid", S_AWVALID, 0);
    chk("single_resp_busy", BUSY, 1);
    cyc();
    S_BVALID = 1'b0;
    chk("single_done_busy", BUSY, 0);
    chk("single_done_bvalid", M_BVALID, 0);
    ARESETn = 1'b0;
    cyc();
    ARESETn = 1'b1;
    M_AWADDR = {32'h200, 32'h100}; M_AWVALID = 2'b11; M_WVALID = 2'b11; S_BVALID = 1'b1;
    for (int t = 0; t < 4; t++) begin
      cyc();
      chk("cont_grant", GRANT, t % 2);
      chk("cont_awaddr", S_AWADDR, (t % 2) ? 32'h200 : 32'h100);
      cyc();
      chk("cont_bvalid", M_BVALID, (t % 2) ? 2 : 1);
      cyc();
      chk("cont_idle", BUSY, 0);
    end
    M_AWVALID = '0; M_WVALID = '0;
    M_AWADDR = {32'h300, 32'h100}; M_WDATA[63:32] = 32'hCAFEF00D; M_WSTRB[7:4] = 4'h3;
    M_BREADY = 2'b00; S_AWREADY = 1'b1; S_WREADY = 1'b0; S_BVALID = 1'b1; S_BRESP = 2'b10;
    M_AWVALID = 2'b10;
    cyc();
    M_AWVALID = 2'b11;
    #1;
    chk("dec_grant", GRANT, 1);
    chk("dec_awaddr", S_AWADDR, 32'h300);
    chk("dec_awready", M_AWREADY, 2'b10);
    chk("dec_addr_bready", S_BREADY, 0);
    cyc();
    M_AWVALID = 2'b01;
    #1;
    chk("dec_aw_done", S_AWVALID, 0);
    chk("dec_awready_m0", M_AWREADY, 0);
    chk("dec_wait_busy", BUSY, 1);
    cyc(); cyc();
    M_WVALID = 2'b10;
    #1;
    chk("dec_wvalid", S_WVALID, 1);
    chk("dec_wready_low", M_WREADY, 0);
    cyc();
    chk("dec_no_resp", M_BVALID, 0);
    chk("dec_no_bready", S_BREADY, 0);
    chk("dec_m0_blocked", M_AWREADY, 0);
    S_WREADY = 1'b1;
    #1;
    chk("dec_wready", M_WREADY, 2'b10);
    chk("dec_wdata", S_WDATA, 32'hCAFEF00D);
    chk("dec_wstrb", S_WSTRB, 4'h3);
    cyc();
    M_WVALID = '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid", M_BVALID, 2'b10);
      chk("bp_bresp", M_BRESP, 2'b10);
      chk("bp_bready", S_BREADY, 0);
      if (i < 4) cyc();
    end
    M_BREADY = 2'b10;
    #1;
    chk("bp_release", S_BREADY, 1);
    cyc();
    chk("bp_idle_busy", BUSY, 0);
    chk("bp_idle_grant", GRANT, 1);
    chk("bp_idle_bready", S_BREADY, 0);
    chk("bp_idle_bvalid", M_BVALID, 0);
    cyc();
    chk("m0_not_lost", GRANT, 0);
    chk("m0_busy", BUSY, 1);
    M_WVALID = 2'b01; S_BVALID = 1'b0;
    cyc();
    M_AWVALID = '0; M_WVALID = '0; S_BVALID = 1'b1; M_BREADY = 2'b01;
    cyc();
    M_AWVALID = 2'b10; M_WVALID = 2'b10; M_BREADY = 2'b00;
    cyc(); cyc();
    M_AWVALID = '0; M_WVALID = '0;
    #1;
    chk("rst_pre_grant", GRANT, 1);
    chk("rst_pre_bvalid", M_BVALID, 2'b10);
    ARESETn = 1'b0;
    cyc();
    ARESETn = 1'b1;
    #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_grant", GRANT, 0);
    chk("rst_bvalid", M_BVALID, 0);
    chk("rst_bready", S_BREADY, 0);
    chk("rst_awvalid", S_AWVALID, 0);
    chk("rst_wready", M_WREADY, 0);
    M_AWVALID = 2'b11; M_WVALID = 2'b11;
    cyc();
    chk("rst_next_grant", GRANT, 0);
    chk("rst_next_awaddr", S_AWADDR, 32'h100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
